// File: rtl/fetch.sv
// fetch: instruction fetch stage with PC, one-outstanding memory port,
// credit-checked buffer, redirect flush and AXI-Stream output to decode.
//
// Ports:
//   aclk, areset        clock, synchronous active-high reset
//   imem_req_*          request (valid/ready/addr)
//   imem_rsp_*          response, one cycle after acceptance
//   redirect, target    taken branch/jump from execute
//   down_t*             {pc, ir} stream toward decode
//   misaligned          one-cycle pulse for a target with low bits set
module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        aclk,
  input  logic        areset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic        down_tvalid,
  input  logic        down_tready,
  output logic [63:0] down_tdata,
  output logic        misaligned
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1) + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t LAST    = ptr_t'(DEPTH - 1);
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ia_q;
  logic        infl_q;
  logic        drop_q;
  logic        mis_q;
  cnt_t        cnt_q, cnt_d;
  ptr_t        wp_q, wp_d;
  ptr_t        rp_q, rp_d;
  logic [63:0] mem_q [DEPTH];

  logic pop;
  logic push;
  logic accept;
  cnt_t occ;
  cnt_t lim;

  function automatic ptr_t inc(input ptr_t p);
    return (p == LAST) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    down_tvalid = ~areset & (cnt_q != '0);
    down_tdata  = mem_q[rp_q];
    pop         = down_tvalid & down_tready;
    // occupancy + outstanding must stay below DEPTH, a pop frees a slot
    occ            = cnt_q + cnt_t'(infl_q);
    lim            = DEPTH_C + cnt_t'(pop);
    imem_req_valid = ~areset & ~redirect & (occ < lim);
    imem_req_addr  = pc_q;
    accept         = imem_req_valid & imem_req_ready;
    // a response meeting a redirect belongs to the old path
    push = ~areset & ~redirect & imem_rsp_valid & infl_q & ~drop_q;
    misaligned = mis_q;

    pc_d  = pc_q;
    cnt_d = cnt_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (redirect) begin
      pc_d  = {target[31:2], 2'b00};
      cnt_d = '0;
      wp_d  = '0;
      rp_d  = '0;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (push)   wp_d = inc(wp_q);
      if (pop)    rp_d = inc(rp_q);
      cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pc_q   <= RESET_ADDR;
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      infl_q <= 1'b0;
      drop_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      infl_q <= accept;
      // guards against a late stale beat after a flush
      drop_q <= redirect & infl_q;
      mis_q  <= redirect & (target[1:0] != 2'b00);
    end
  end

  always_ff @(posedge aclk) begin
    if (accept) ia_q <= pc_q;
    if (push)   mem_q[wp_q] <= {ia_q, imem_rsp_data};
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard plus table-driven redirect vectors for fetch.
// Memory model answers one cycle after each accepted request.
module tb_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST   = 32'h0000_0000;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] target = 32'h0;
  logic        down_tvalid;
  logic        down_tready = 1'b1;
  logic [63:0] down_tdata;
  logic        misaligned;

  fetch #(.RESET_ADDR(RST), .DEPTH(DEPTH)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .target         (target),
    .down_tvalid    (down_tvalid),
    .down_tready    (down_tready),
    .down_tdata     (down_tdata),
    .misaligned     (misaligned)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'h13 | (a << 8);
  endfunction

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // memory model
  logic        acc_n = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic        spur = 1'b0;

  always begin
    logic v;
    logic s;
    logic [31:0] a;
    @(posedge aclk);
    v = acc_n;
    s = spur;
    a = acc_addr;
    #1;
    imem_rsp_valid = v | s;
    imem_rsp_data  = v ? f(a) : 32'hDEAD_BEEF;
  end

  // scoreboard: entries accepted and not yet consumed or flushed
  logic [63:0] q[$];
  logic [31:0] exp_pc = RST;
  logic        exp_infl = 1'b0;
  logic        mis_exp = 1'b0;
  int          cnt;
  logic        ev, rv, pp;

  always @(negedge aclk) begin
    chk("misaligned", 64'(misaligned), 64'(mis_exp));
    if (areset) begin
      chk("rst_tvalid", 64'(down_tvalid), 64'(0));
      chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
      q.delete();
      exp_pc   = RST;
      exp_infl = 1'b0;
      mis_exp  = 1'b0;
    end else begin
      cnt = q.size() - int'(exp_infl);
      ev  = (cnt != 0);
      chk("tvalid", 64'(down_tvalid), 64'(ev));
      pp  = ev & down_tready;
      rv  = !redirect && ((q.size() - int'(pp)) < DEPTH);
      chk("req_valid", 64'(imem_req_valid), 64'(rv));
      if (pp) begin
        chk("tdata", down_tdata, q[0]);
        void'(q.pop_front());
        pops++;
      end
      mis_exp = redirect && (target[1:0] != 2'b00);
      if (redirect) begin
        q.delete();
        exp_pc   = {target[31:2], 2'b00};
        exp_infl = 1'b0;
      end else if (rv && imem_req_ready) begin
        chk("req_addr", 64'(imem_req_addr), 64'(exp_pc));
        q.push_back({exp_pc, f(exp_pc)});
        exp_pc   = exp_pc + 32'd4;
        exp_infl = 1'b1;
      end else begin
        exp_infl = 1'b0;
      end
    end
    acc_n    = imem_req_valid & imem_req_ready;
    acc_addr = imem_req_addr;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        mis;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int p0;
    int k;
    tbl[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 1'b0};
    tbl[1] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104, 1'b1};
    tbl[2] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 1'b1};
    tbl[3] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    tbl[4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004, 1'b1};

    // reset release and full throughput
    repeat (3) tick();
    areset = 1'b0;
    tick();
    tick();
    p0 = pops;
    repeat (10) tick();
    chk("throughput", 64'(pops - p0), 64'(10));

    // stall with fresh start: exactly DEPTH entries held
    areset = 1'b1;
    down_tready = 1'b0;
    tick();
    areset = 1'b0;
    repeat (5) tick();
    chk("stall_tvalid", 64'(down_tvalid), 64'(1));
    chk("stall_req_valid", 64'(imem_req_valid), 64'(0));
    imem_req_ready = 1'b0;
    down_tready = 1'b1;
    p0 = pops;
    repeat (DEPTH + 2) tick();
    chk("stall_drain", 64'(pops - p0), 64'(DEPTH));
    imem_req_ready = 1'b1;
    repeat (4) tick();

    // redirect vectors
    foreach (tbl[i]) begin
      redirect = 1'b1;
      target   = tbl[i].tgt;
      tick();
      redirect = 1'b0;
      chk("mis_pulse", 64'(misaligned), 64'(tbl[i].mis));
      tick();
      chk("mis_clear", 64'(misaligned), 64'(0));
      k = 0;
      while (!down_tvalid && k < 10) begin
        tick();
        k++;
      end
      chk("redir_timeout", 64'(k < 10), 64'(1));
      chk("redir_pc0", 64'(down_tdata[63:32]), 64'(tbl[i].pc0));
      chk("redir_ir0", 64'(down_tdata[31:0]), 64'(f(tbl[i].pc0)));
      tick();
      chk("redir_pc1", 64'(down_tdata[63:32]), 64'(tbl[i].pc1));
    end

    // back-to-back redirects: last wins
    redirect = 1'b1;
    target   = 32'h0000_0300;
    tick();
    target   = 32'h0000_0400;
    tick();
    redirect = 1'b0;
    k = 0;
    while (!down_tvalid && k < 10) begin
      tick();
      k++;
    end
    chk("b2b_pc", 64'(down_tdata[63:32]), 64'(32'h400));

    // random backpressure on both sides
    for (int c = 0; c < 1000; c++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      down_tready    = ($urandom_range(0, 3) != 0);
      tick();
    end
    imem_req_ready = 1'b1;
    down_tready    = 1'b1;
    repeat (4) tick();

    // reset with a full buffer, spurious beat right after reset
    down_tready = 1'b0;
    repeat (5) tick();
    chk("pre_rst_tvalid", 64'(down_tvalid), 64'(1));
    areset = 1'b1;
    spur   = 1'b1;
    tick();
    chk("post_rst_tvalid", 64'(down_tvalid), 64'(0));
    areset = 1'b0;
    spur   = 1'b0;
    down_tready = 1'b1;
    k = 0;
    while (!down_tvalid && k < 10) begin
      tick();
      k++;
    end
    chk("restart_pc", 64'(down_tdata[63:32]), 64'(RST));
    chk("restart_ir", 64'(down_tdata[31:0]), 64'(f(RST)));
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_ADDR, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 2, instruction buffer entries (legal 2..8).
REQ-003 aclk  in  1  clock; all state updates on its rising edge.
REQ-004 areset  in  1  reset, synchronous and active-high.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts request.
REQ-007 imem_req_addr  out  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  in  1  read data valid; exactly one cycle after each accepted request.
REQ-009 imem_rsp_data  in  32  instruction word.
REQ-010 redirect  in  1  branch/jump taken; one-cycle pulse from execute.
REQ-011 target  in  32  redirect destination address.
REQ-012 down_tvalid  out  1  AXI-Stream valid toward decode.
REQ-013 down_tready  in  1  decode ready.
REQ-014 down_tdata  out  64  {pc[63:32], ir[31:0]}.
REQ-015 misaligned  out  1  one-cycle error pulse for a target with nonzero bits [1:0].

Function
REQ-016 pc register holds the next fetch address; imem_req_addr = pc.
REQ-017 Request accepted when imem_req_valid & imem_req_ready; pc increments by 4 on acceptance, wrapping 32'hFFFF_FFFC -> 0.
REQ-018 inflight flag set on acceptance, cleared the next cycle; at most one request outstanding.
REQ-019 imem_req_valid = ~redirect & (count + inflight - pop < DEPTH), where count is buffer occupancy and pop = down_tvalid & down_tready.
REQ-020 Credit rule: buffer never overflows; a response never arrives to a full buffer.
REQ-021 Each response stores {address of its request, imem_rsp_data} in the FIFO unless marked for drop.
REQ-022 down_tvalid = (count != 0); down_tdata = oldest entry; stable while down_tvalid & ~down_tready.
REQ-023 Simultaneous push and pop: count unchanged, order preserved.
REQ-024 Full throughput: with imem_req_ready and down_tready held high, one instruction per cycle after a 2-cycle initial latency.
REQ-025 On redirect: flush buffer (count <= 0), pc <= {target[31:2], 2'b00}, no request that cycle.
REQ-026 On redirect with inflight = 1, the response arriving next cycle is dropped.
REQ-027 Redirect concurrent with a pop: flush wins and the popped entry counts as consumed.
REQ-028 Redirect and response in the same cycle: the response is discarded.
REQ-029 misaligned = redirect & (target[1:0] != 0), registered and asserted the next cycle for exactly one cycle.
REQ-030 Back-to-back redirects: the last one wins; each flushes and restarts.
REQ-031 A request presented while imem_req_ready = 0 holds the same address until accepted; redirect may withdraw it.

Reset
REQ-032 While areset = 1: pc <= RESET_ADDR, count <= 0, inflight <= 0, drop <= 0, misaligned <= 0.
REQ-033 While areset = 1: down_tvalid = 0 and imem_req_valid = 0.
REQ-034 First request is issued in the cycle after areset deasserts.
REQ-035 Reset mid-operation: buffered and in-flight data is discarded; a response in the cycle after reset is ignored.

Verification
REQ-036 Reset release, memory returns 32'h0000_0013 and then other words, ready high -> down_tdata = {0, 32'h13}, {4, ...}, {8, ...} on consecutive cycles after 2-cycle latency.
REQ-037 down_tready low for 5 cycles -> exactly DEPTH entries buffered, imem_req_valid low, no data lost; release -> in-order pcs 0, 4.
REQ-038 redirect with target 32'h100 while inflight -> stale response dropped; next down_tdata pc = 32'h100.
REQ-039 redirect target 32'h102 -> misaligned pulses one cycle; fetch proceeds at 32'h100.
REQ-040 imem_req_ready toggled randomly for 1000 cycles -> pcs strictly +4 sequential and no buffer overflow.
REQ-041 areset asserted with 2 buffered entries -> down_tvalid = 0 next cycle; fetch restarts at RESET_ADDR.
